// File: rtl/alu_serial_exec.sv
// Execute unit with valid/ready handshakes on both sides.
// Logic, add/sub and compares take one cycle; shifts move one bit position per cycle.
module alu_serial_exec #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      Operation,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   work_q, work_d;
    logic [SHW-1:0]    count_q, count_d;
    logic [1:0]        shOp_q, shOp_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;

    logic              isShift;
    logic              accept;
    logic [XLEN-1:0]   quickResult;
    logic [XLEN-1:0]   shiftStep;

    assign isShift = (Operation == 4'b0101) || (Operation == 4'b0110) ||
                     (Operation == 4'b0111);

    always_comb begin
        quickResult = '0;
        case (Operation)
            4'b0000: quickResult = SrcA & SrcB;
            4'b0001: quickResult = SrcA ^ SrcB;
            4'b0010: quickResult = SrcA + SrcB;
            4'b0011: quickResult = SrcA | SrcB;
            4'b0100: quickResult = SrcA - SrcB;
            4'b1000: quickResult = {{(XLEN-1){1'b0}}, (SrcA == SrcB)};
            4'b1100: quickResult = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: quickResult = '0;
        endcase
    end

    // The low two opcode bits distinguish the shifts: 01 SRL, 10 SLL, 11 SRA.
    always_comb begin
        shiftStep = '0;
        case (shOp_q)
            2'b01:   shiftStep = {1'b0, work_q[XLEN-1:1]};
            2'b10:   shiftStep = {work_q[XLEN-2:0], 1'b0};
            default: shiftStep = {work_q[XLEN-1], work_q[XLEN-1:1]};
        endcase
    end

    assign in_ready  = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign ALUResult = result_q;
    assign Zero      = zero_q;

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        count_d  = count_q;
        shOp_d   = shOp_q;
        result_d = result_q;
        zero_d   = zero_q;

        if (state_q == SHIFT) begin
            if (count_q != '0) begin
                work_d  = shiftStep;
                count_d = count_q - SHW'(1);
            end else begin
                result_d = work_q;
                zero_d   = (work_q == '0);
                state_d  = DONE;
            end
        end else if (accept) begin
            if (isShift) begin
                work_d  = SrcA;
                count_d = SrcB[SHW-1:0];
                shOp_d  = Operation[1:0];
                state_d = SHIFT;
            end else begin
                result_d = quickResult;
                zero_d   = (quickResult == '0);
                state_d  = DONE;
            end
        end else if ((state_q == DONE) && out_ready) begin
            state_d = IDLE;
        end

        // Flush wins over everything; the held result stays but is no longer valid.
        if (flush) begin
            state_d = IDLE;
            work_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            count_q  <= '0;
            shOp_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            count_q  <= count_d;
            shOp_q   <= shOp_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_serial_exec.sv
// Self-checking bench for alu_serial_exec: a transaction-level latency/result model
// compared every cycle, plus directed vectors with hand-computed expectations.
module tb_alu_serial_exec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] ALUResult;
    logic        Zero;

    int vectorCount = 0;
    int missCount   = 0;
    int cyc         = 0;

    alu_serial_exec #(.XLEN(32), .SHW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .Zero      (Zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    function automatic logic [31:0] modelResult(input logic [3:0] op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        int unsigned sh;
        sh = b[4:0];
        case (op)
            4'd0:    return a & b;
            4'd1:    return a ^ b;
            4'd2:    return a + b;
            4'd3:    return a | b;
            4'd4:    return a - b;
            4'd5:    return a >> sh;
            4'd6:    return a << sh;
            4'd7:    return 32'($signed(a) >>> sh);
            4'd8:    return (a == b) ? 32'd1 : 32'd0;
            4'd12:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit modelIsShift(input logic [3:0] op);
        return (op == 4'd5) || (op == 4'd6) || (op == 4'd7);
    endfunction

    typedef struct {
        logic [31:0] res;
        int          readyAt;
    } entry_t;

    entry_t pend[$];

    // Model: an accepted op becomes visible 1 cycle later (shift: amount + 2),
    // and stays visible until it is taken by out_ready or dropped by flush.
    always @(negedge clk) begin
        bit     expValid;
        bit     expReady;
        entry_t e;
        if (!rst_n) begin
            pend.delete();
        end else begin
            expValid = (pend.size() > 0) && (cyc >= pend[0].readyAt);
            expReady = !flush && ((pend.size() == 0) || (expValid && out_ready));
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, expValid});
            checkOutput("in_ready", {31'd0, in_ready}, {31'd0, expReady});
            if (expValid) begin
                checkOutput("ALUResult", ALUResult, pend[0].res);
                checkOutput("Zero", {31'd0, Zero}, {31'd0, (pend[0].res == 32'd0)});
            end
            if (flush) begin
                pend.delete();
            end else begin
                if (expValid && out_ready) void'(pend.pop_front());
                if (in_valid && expReady) begin
                    e.res     = modelResult(Operation, SrcA, SrcB);
                    e.readyAt = modelIsShift(Operation) ? (cyc + 2 + int'(SrcB[4:0])) : (cyc + 1);
                    pend.push_back(e);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        in_valid  = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitValid(output int lat);
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) checkOutput("wait out_valid timeout", 32'd0, 32'd1);
    endtask

    task automatic runOp(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expRes,
                         input logic expZero, input int expLat);
        int lat;
        out_ready = 1'b1;
        applyStimulus(op, a, b);
        waitValid(lat);
        checkOutput({name, " latency"}, lat, expLat);
        checkOutput({name, " result"}, ALUResult, expRes);
        checkOutput({name, " zero"}, {31'd0, Zero}, {31'd0, expZero});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        logic [3:0]  b2bOp[4];
        logic [31:0] b2bA[4];
        logic [31:0] b2bB[4];

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        Operation = 4'd0;
        SrcA      = 32'd0;
        SrcB      = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset ALUResult", ALUResult, 32'd0);
        checkOutput("reset Zero", {31'd0, Zero}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        runOp("ADD wrap", 4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1);
        runOp("SUB zero", 4'b0100, 32'd5, 32'd5, 32'd0, 1'b1, 1);
        runOp("SRA 4", 4'b0111, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 6);
        runOp("SLL 0", 4'b0110, 32'hA5A5_0F0F, 32'd0, 32'hA5A5_0F0F, 1'b0, 2);
        runOp("SRL 31", 4'b0101, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 33);
        runOp("SLL 31", 4'b0110, 32'd3, 32'h0000_00FF, 32'h8000_0000, 1'b0, 33);
        runOp("SRL 8", 4'b0101, 32'hFF00_0000, 32'd8, 32'h00FF_0000, 1'b0, 10);
        runOp("SLT neg", 4'b1100, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
        runOp("SLT pos", 4'b1100, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1);
        runOp("EQ", 4'b1000, 32'h1234, 32'h1234, 32'd1, 1'b0, 1);
        runOp("code 1111", 4'b1111, 32'hDEAD_BEEF, 32'h1, 32'd0, 1'b1, 1);
        runOp("AND", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1);
        runOp("OR", 4'b0011, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1);

        // Back-to-back issue with out_ready held high.
        b2bOp = '{4'b0010, 4'b0001, 4'b0100, 4'b1000};
        b2bA  = '{32'd10, 32'hAAAA_AAAA, 32'd0, 32'd7};
        b2bB  = '{32'd20, 32'h5555_5555, 32'd1, 32'd8};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            Operation = b2bOp[i];
            SrcA      = b2bA[i];
            SrcB      = b2bB[i];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Backpressure with a queued op waiting behind the held result.
        out_ready = 1'b0;
        applyStimulus(4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        waitValid(lat);
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        Operation = 4'b0011;
        SrcA      = 32'd1;
        SrcB      = 32'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("held result", ALUResult, 32'hFF00_FF00);
            checkOutput("held in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("queued op valid", {31'd0, out_valid}, 32'd1);
        checkOutput("queued op result", ALUResult, 32'd3);
        @(posedge clk);
        #1;

        // Reset in the middle of a shift.
        applyStimulus(4'b0101, 32'hFFFF_0000, 32'd16);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid-shift reset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid-shift reset ALUResult", ALUResult, 32'd0);
        checkOutput("mid-shift reset Zero", {31'd0, Zero}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("after reset in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Flush during SHIFT.
        applyStimulus(4'b0101, 32'hFFFF_0000, 32'd20);
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush shift in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            checkOutput("flushed shift no result", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Flush while a result is held in DONE.
        out_ready = 1'b0;
        applyStimulus(4'b0000, 32'h0000_FFFF, 32'h0000_0F0F);
        waitValid(lat);
        checkOutput("pre-flush result", ALUResult, 32'h0000_0F0F);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("flushed done out_valid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Flush together with in_valid: the op must be dropped.
        flush     = 1'b1;
        in_valid  = 1'b1;
        Operation = 4'b0010;
        SrcA      = 32'd2;
        SrcB      = 32'd3;
        @(negedge clk);
        checkOutput("flush+valid in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("flush+valid not accepted", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        runOp("ADD after flush", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
